mem_arbiter: RTL

//  Shares the single memory4c instance between the I-cache and D-cache fill FSMs.

---
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shares one memory4c port between the I-cache and D-cache fill engines: 8-word block fills and D-side write-through.
// Build option: define ARB_RR_EN to break request ties in favour of the requester that did not own the previous transaction.
//
// state | meaning
// IDLE  | no owner; arbitrate between i_req and d_req
// FILL  | issue 8 block reads, route 8 returns to the owner
// WRITE | single-cycle D-cache write-through
module mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int MEM_LAT     = 4,
    parameter int BLOCK_WORDS = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_req,
    input  logic [ADDR_W-1:0]              i_addr,
    output logic                           i_grant,
    output logic                           i_data_valid,
    input  logic                           d_req,
    input  logic                           d_wr,
    input  logic [ADDR_W-1:0]              d_addr,
    input  logic [DATA_W-1:0]              d_wdata,
    output logic                           d_grant,
    output logic                           d_data_valid,
    output logic                           d_wr_done,
    output logic [DATA_W-1:0]              rd_data,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_wdata,
    output logic                           mem_enable,
    output logic                           mem_wr,
    input  logic [DATA_W-1:0]              mem_data_out,
    input  logic                           mem_data_valid,
    output logic                           busy
);

    localparam int WORD_BITS = $clog2(BLOCK_WORDS);
    localparam int OFF       = WORD_BITS + 1;
    localparam int LAT_W     = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    // owner doubles as the last-owner record once the transaction ends (1 = D)
    logic                   owner;
    logic [WORD_BITS:0]     issue_cnt;
    logic [WORD_BITS-1:0]   ret_cnt;
    logic [LAT_W-1:0]       lat_cnt;
    logic [ADDR_W-1:0]      addr_lat;
    logic [DATA_W-1:0]      wdata_lat;

    logic                   any_req;
    logic                   win_d;
    logic                   issue_active;
    logic                   ret_ok;
    logic                   last_ret;

    assign any_req = i_req | d_req;

    always_comb begin
`ifdef ARB_RR_EN
        win_d = d_req & (~i_req | ~owner);
`else
        win_d = d_req;
`endif
    end

    assign issue_active = (state == FILL) && (issue_cnt < (WORD_BITS + 1)'(BLOCK_WORDS));
    // returns cannot legally precede the first issue by less than MEM_LAT, so
    // stale data from a fill aborted by reset is never counted
    assign ret_ok       = (state == FILL) && mem_data_valid && (lat_cnt == '0);
    assign last_ret     = ret_ok && (ret_cnt == WORD_BITS'(BLOCK_WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = (win_d && d_wr) ? WRITE : FILL;
                end
            end
            FILL: begin
                if (last_ret) begin
                    state_nxt = IDLE;
                end
            end
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= 1'b0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            lat_cnt   <= '0;
            addr_lat  <= '0;
            wdata_lat <= '0;
        end else if (state == IDLE) begin
            if (any_req) begin
                owner     <= win_d;
                addr_lat  <= win_d ? d_addr : i_addr;
                wdata_lat <= d_wdata;
                issue_cnt <= '0;
                ret_cnt   <= '0;
                lat_cnt   <= LAT_W'(MEM_LAT);
            end
        end else if (state == FILL) begin
            if (issue_active) begin
                issue_cnt <= issue_cnt + 1'b1;
            end
            if (lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            if (ret_ok) begin
                ret_cnt <= ret_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        busy         = (state != IDLE);
        i_grant      = (state != IDLE) && !owner;
        d_grant      = (state != IDLE) && owner;
        mem_enable   = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        d_wr_done    = 1'b0;
        i_data_valid = 1'b0;
        d_data_valid = 1'b0;
        rd_data      = '0;
        fill_word    = '0;
        case (state)
            FILL: begin
                if (issue_active) begin
                    mem_enable = 1'b1;
                    mem_addr   = {addr_lat[ADDR_W-1:OFF], issue_cnt[WORD_BITS-1:0], 1'b0};
                end
                if (ret_ok) begin
                    i_data_valid = !owner;
                    d_data_valid = owner;
                    rd_data      = mem_data_out;
                    fill_word    = ret_cnt;
                end
            end
            WRITE: begin
                mem_enable = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = addr_lat;
                mem_wdata  = wdata_lat;
                d_wr_done  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
